// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//
// Round-robin, packet-locked arbiter that lets N stream requesters share the
// single stream input of uart_tx. Once a requester wins, it keeps the grant
// until it sends a beat with tlast. Bytes from different sources therefore
// never interleave on the serial line. An optional beat limit (ML) forces a
// release, so one requester cannot hold the UART forever. Any beats it has
// left then compete again as a fresh packet.
//
// Parameters:
//   N  - number of requesters (2..16)
//   DW - data width, must match uart_tx DW (>= 4 when the header is enabled)
//   ML - max beats per grant, 0 = unlimited (release only on tlast)
//
// Optional feature macro: UART_TX_ARB_ID_EN
//   When defined, every grant starts with one header beat carrying the
//   4-bit index of the granted requester in the low bits of m_tdata.
//   The header does not count toward ML.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   s_tvalid  in   [N]     per-requester valid
//   s_tready  out  [N]     per-requester ready (only the owner sees m_tready)
//   s_tdata   in   [N*DW]  flattened requester data, requester i at [i*DW +: DW]
//   s_tlast   in   [N]     per-requester end of packet
//   m_tvalid  out          to uart_tx str_tvalid
//   m_tready  in           from uart_tx str_tready
//   m_tdata   out  [DW]    to uart_tx str_tdata
//   m_tlast   out          end of packet (also forced by the ML limit)
//   grant     out  [N]     one-hot current owner, zero when idle
//   busy      out          a grant is held
// ---------------------------------------------------------------------------
module uart_tx_arb #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int ML = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    s_tvalid,
    output logic [N-1:0]    s_tready,
    input  logic [N*DW-1:0] s_tdata,
    input  logic [N-1:0]    s_tlast,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic [DW-1:0]   m_tdata,
    output logic            m_tlast,
    output logic [N-1:0]    grant,
    output logic            busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (ML > 0) ? $clog2(ML + 1) : 1;
    // Count value at which the current beat is the last one allowed.
    localparam logic [CW-1:0] CNT_LAST = CW'((ML > 0) ? (ML - 1) : 0);

`ifdef UART_TX_ARB_ID_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   gidx_q,  gidx_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;

    // Round-robin search: scan requesters from ptr upward with wrap-around.
    // The first valid one wins. The winner is only consumed in IDLE.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!win_found && s_tvalid[IW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    // Next-state and output logic. In DATA the owner is passed straight
    // through. Release happens on the beat that carries m_tlast. The
    // following cycle is always an idle arbitration cycle, so a release and
    // a new grant never share an edge.
    always_comb begin
        logic sel_valid;
        logic sel_last;
        int   nxt;

        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        m_tvalid  = 1'b0;
        m_tdata   = '0;
        m_tlast   = 1'b0;
        s_tready  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        nxt       = 0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d = N'(1) << win_idx;
                    gidx_d  = win_idx;
`ifdef UART_TX_ARB_ID_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_DATA;
`endif
                end
            end

`ifdef UART_TX_ARB_ID_EN
            // The header beat is generated locally, so no requester is
            // handshaken while it is on the bus.
            ST_HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = DW'(gidx_q);
                if (m_tready) begin
                    state_d = ST_DATA;
                end
            end
`endif

            ST_DATA: begin
                sel_valid        = s_tvalid[gidx_q];
                sel_last         = s_tlast[gidx_q] | ((ML != 0) && (cnt_q == CNT_LAST));
                m_tvalid         = sel_valid;
                m_tdata          = s_tdata[int'(gidx_q) * DW +: DW];
                m_tlast          = sel_last;
                s_tready[gidx_q] = m_tready;
                if (sel_valid && m_tready) begin
                    if (sel_last) begin
                        nxt = int'(gidx_q) + 1;
                        if (nxt >= N) begin
                            nxt = 0;
                        end
                        state_d = ST_IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                        ptr_d   = IW'(nxt);
                    end else if (ML != 0) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers. An asynchronous reset drops any packet in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
//
// Scoreboard bench for uart_tx_arb. Two instances are used: one with the
// default unlimited beat count and one with ML=2. A select flag routes the
// requester stimulus to one of them and muxes its outputs back. Stimulus
// pushes requester beats into per-source queues and pushes the expected
// output beats into a scoreboard queue. A monitor pops and compares on every
// accepted output beat. It also checks that an idle cycle separates
// consecutive grants.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int DW = 8;

`ifdef UART_TX_ARB_ID_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0]  grant;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            active;
    logic [N-1:0]    sValid;
    logic [N*DW-1:0] sData;
    logic [N-1:0]    sLast;
    logic            mReady;

    logic [N-1:0]    v0, vMl;
    logic [N-1:0]    r0, rMl;
    logic            m0Valid, mMlValid;
    logic [DW-1:0]   m0Data, mMlData;
    logic            m0Last, mMlLast;
    logic [N-1:0]    g0, gMl;
    logic            b0, bMl;

    logic [N-1:0]    sReady;
    logic            mValid;
    logic [DW-1:0]   mData;
    logic            mLast;
    logic [N-1:0]    grantAct;
    logic            busyAct;

    logic [DW:0]     srcQ [N][$];
    exp_t            expQ [$];
    exp_t            monExp;
    logic [N-1:0]    prevGrant = '0;
    logic [N-1:0]    fire;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Route the requester valids to the selected instance only.
    assign v0  = active ? '0 : sValid;
    assign vMl = active ? sValid : '0;

    uart_tx_arb #(.N(N), .DW(DW), .ML(0)) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(v0), .s_tready(r0), .s_tdata(sData), .s_tlast(sLast),
        .m_tvalid(m0Valid), .m_tready(mReady), .m_tdata(m0Data), .m_tlast(m0Last),
        .grant(g0), .busy(b0)
    );

    uart_tx_arb #(.N(N), .DW(DW), .ML(2)) dutMl (
        .clk(clk), .rst(rst),
        .s_tvalid(vMl), .s_tready(rMl), .s_tdata(sData), .s_tlast(sLast),
        .m_tvalid(mMlValid), .m_tready(mReady), .m_tdata(mMlData), .m_tlast(mMlLast),
        .grant(gMl), .busy(bMl)
    );

    assign sReady   = active ? rMl      : r0;
    assign mValid   = active ? mMlValid : m0Valid;
    assign mData    = active ? mMlData  : m0Data;
    assign mLast    = active ? mMlLast  : m0Last;
    assign grantAct = active ? gMl      : g0;
    assign busyAct  = active ? bMl      : b0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    // Queue one beat on a requester.
    task automatic applyStimulus(input int id, input logic [DW-1:0] data, input logic last);
        srcQ[id].push_back({last, data});
    endtask

    task automatic expectBeat(input int id, input logic [DW-1:0] data, input logic last);
        exp_t e;
        e.grant = N'(1) << id;
        e.data  = data;
        e.last  = last;
        expQ.push_back(e);
    endtask

    // Every grant opens with a header beat when the ID feature is built in.
    task automatic expectGrant(input int id);
        if (ID_EN) begin
            expectBeat(id, DW'(id), 1'b0);
        end
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("drainTimeout", expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic waitBusy(input int budget);
        int n;
        n = 0;
        while (!busyAct && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("busyTimeout", busyAct, 1);
    endtask

    // The grant must drop on the cycle after the last beat.
    task automatic checkReleased(input string name);
        @(negedge clk);
        checkOutput(name, grantAct, 0);
        checkOutput({name, "Busy"}, busyAct, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Source driver: the handshake is sampled at the falling edge. The
    // next beat is presented just after the rising edge.
    initial begin
        sValid = '0;
        sData  = '0;
        sLast  = '0;
        forever begin
            @(negedge clk);
            fire = sValid & sReady;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i] && srcQ[i].size() > 0) begin
                    void'(srcQ[i].pop_front());
                end
                if (srcQ[i].size() > 0) begin
                    sValid[i]           = 1'b1;
                    sData[i*DW +: DW]   = srcQ[i][0][DW-1:0];
                    sLast[i]            = srcQ[i][0][DW];
                end else begin
                    sValid[i]           = 1'b0;
                    sData[i*DW +: DW]   = '0;
                    sLast[i]            = 1'b0;
                end
            end
        end
    end

    // Monitor: pops and compares every accepted output beat, and checks
    // that an idle cycle separates consecutive grants.
    always @(negedge clk) begin
        if (prevGrant != '0 && grantAct != prevGrant) begin
            checkOutput("idleGap", grantAct, 0);
        end
        prevGrant <= grantAct;
        if (mValid && mReady) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedBeat: got data 0x%0h grant 0x%0h, expected no beat",
                         mData, grantAct);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("beatData",  mData,    monExp.data);
                checkOutput("beatLast",  mLast,    monExp.last);
                checkOutput("beatGrant", grantAct, monExp.grant);
            end
        end
    end

    initial begin
        int n;
        logic [5:0] readyPat;

        rst    = 1'b0;
        active = 1'b0;
        mReady = 1'b1;
        #2;
        $display("[TB] reset state");
        checkOutput("rstGrant",  grantAct, 0);
        checkOutput("rstBusy",   busyAct,  0);
        checkOutput("rstValid",  mValid,   0);
        checkOutput("rstData",   mData,    0);
        checkOutput("rstLast",   mLast,    0);
        checkOutput("rstReady",  sReady,   0);
        checkOutput("rstGrantMl", gMl,     0);
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Single requester, 3-beat packet, with grant latency.
        $display("[TB] single requester");
        @(negedge clk);
        #1;
        applyStimulus(1, 8'h11, 1'b0);
        applyStimulus(1, 8'h22, 1'b0);
        applyStimulus(1, 8'h33, 1'b1);
        expectGrant(1);
        expectBeat(1, 8'h11, 1'b0);
        expectBeat(1, 8'h22, 1'b0);
        expectBeat(1, 8'h33, 1'b1);
        n = 0;
        while (!sValid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("srcValidSeen", sValid[1], 1);
        checkOutput("arbCycleGrant", grantAct, 0);
        checkOutput("arbCycleValid", mValid, 0);
        @(negedge clk);
        checkOutput("grantLatency", grantAct, 4'b0010);
        checkOutput("grantBusy",    busyAct,  1);
        checkOutput("firstValid",   mValid,   1);
        waitDrain(50);
        checkReleased("releaseT1");

        // Requesters 0 and 2 together, then prove the pointer sits at 3.
        $display("[TB] two requesters");
        doReset();
        applyStimulus(0, 8'hA0, 1'b0);
        applyStimulus(0, 8'hA1, 1'b1);
        applyStimulus(2, 8'hB0, 1'b0);
        applyStimulus(2, 8'hB1, 1'b1);
        expectGrant(0);
        expectBeat(0, 8'hA0, 1'b0);
        expectBeat(0, 8'hA1, 1'b1);
        expectGrant(2);
        expectBeat(2, 8'hB0, 1'b0);
        expectBeat(2, 8'hB1, 1'b1);
        waitDrain(80);
        applyStimulus(0, 8'hD0, 1'b1);
        applyStimulus(1, 8'hD1, 1'b1);
        applyStimulus(3, 8'hD3, 1'b1);
        expectGrant(3);
        expectBeat(3, 8'hD3, 1'b1);
        expectGrant(0);
        expectBeat(0, 8'hD0, 1'b1);
        expectGrant(1);
        expectBeat(1, 8'hD1, 1'b1);
        waitDrain(80);
        checkReleased("releaseT2");

        // Fairness: all four continuously valid with 1-beat packets.
        $display("[TB] fairness");
        doReset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                applyStimulus(i, 8'(16 * (r + 1) + i), 1'b1);
            end
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                expectGrant(i);
                expectBeat(i, 8'(16 * (r + 1) + i), 1'b1);
            end
        end
        waitDrain(120);
        checkReleased("releaseT3");

        // Backpressure on requester 3.
        $display("[TB] backpressure");
        @(negedge clk);
        #1;
        mReady = 1'b0;
        applyStimulus(3, 8'hA5, 1'b0);
        applyStimulus(3, 8'h5A, 1'b1);
        expectGrant(3);
        expectBeat(3, 8'hA5, 1'b0);
        expectBeat(3, 8'h5A, 1'b1);
        waitBusy(20);
        readyPat = 6'b110100;
        for (int k = 0; k < 6; k++) begin
            mReady = readyPat[k];
            @(negedge clk);
            if (k < 2) begin
                checkOutput("bpHoldValid", mValid, 1);
                checkOutput("bpHoldData",  mData, ID_EN ? 8'h03 : 8'hA5);
                checkOutput("bpReady3",    sReady[3], ID_EN ? 1'b0 : mReady);
            end
            #1;
        end
        mReady = 1'b1;
        waitDrain(40);
        checkReleased("releaseT4");

        // ML=2 instance: 3-beat packet is split after beat 2.
        $display("[TB] beat limit");
        rst = 1'b0;
        active = 1'b1;
        doReset();
        applyStimulus(1, 8'h01, 1'b0);
        applyStimulus(1, 8'h02, 1'b0);
        applyStimulus(1, 8'h03, 1'b1);
        expectGrant(1);
        expectBeat(1, 8'h01, 1'b0);
        expectBeat(1, 8'h02, 1'b1);
        expectGrant(1);
        expectBeat(1, 8'h03, 1'b1);
        waitDrain(60);
        checkReleased("releaseT5");

        // Reset mid-packet abandons it; a new packet then passes.
        $display("[TB] reset mid-packet");
        @(negedge clk);
        #1;
        active = 1'b0;
        mReady = 1'b0;
        applyStimulus(2, 8'h77, 1'b0);
        applyStimulus(2, 8'h88, 1'b0);
        applyStimulus(2, 8'h99, 1'b1);
        waitBusy(20);
        #2;
        rst = 1'b0;
        srcQ[2].delete();
        #1;
        checkOutput("midRstGrant", grantAct, 0);
        checkOutput("midRstBusy",  busyAct,  0);
        checkOutput("midRstValid", mValid,   0);
        checkOutput("midRstData",  mData,    0);
        checkOutput("midRstLast",  mLast,    0);
        checkOutput("midRstReady", sReady,   0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst    = 1'b1;
        mReady = 1'b1;
        applyStimulus(2, 8'hC3, 1'b1);
        expectGrant(2);
        expectBeat(2, 8'hC3, 1'b1);
        waitDrain(40);
        checkReleased("releaseT6");

        n = 0;
        for (int i = 0; i < N; i++) begin
            n += srcQ[i].size();
        end
        checkOutput("srcLeftover", n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Backstop in case a bounded wait is somehow bypassed.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
